regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file. It is the next-generation architectural register store for the single-cycle and upcoming pipelined RISC-V cores.
- Adds configurable width, depth and read-port count, optional hardwired zero register, write-to-read bypass, and a sequenced clear-on-reset engine.
- Adds a per-register pending scoreboard for load-use and multi-cycle interlock.
- Sits between the decode stage (read addresses, pending query) and the writeback stage (write port, pending set/clear).

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers (>=2). AW = $clog2(DEPTH).
- NRD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear engine is sweeping.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- pend_set  in  1  mark register pend_addr pending (producer issued).
- pend_addr  in  AW  register to mark pending.
- pend  out  NRD  pend[k] = pending bit of raddr port k.

Behaviour:
- Reset (synchronous, active-high):
  - Sampled high on a clk edge: the FSM enters CLEAR, the sweep pointer goes to 0, all pending bits clear, init_busy=1 from the next cycle.
  - Reset held high keeps the pointer at 0.
  - Reset reasserted mid-sweep restarts the sweep at 0.
- FSM states CLEAR and RUN:
  - CLEAR: each cycle writes 0 to entry ptr and increments ptr. After the entry DEPTH-1 write, moves to RUN (init_busy=0).
  - Total CLEAR length after reset deasserts is DEPTH cycles.
  - During CLEAR: we and pend_set are ignored, every rdata port reads 0, pend=0.
  - RUN: normal operation.
  - No contents are initialised by simulation-only initial blocks; the sweep is the only initialisation.
- Write:
  - In RUN, we=1 updates entry waddr at the clk edge.
  - ZERO_REG=1 with waddr=0: the write is dropped.
  - waddr >= DEPTH (non-power-of-two DEPTH): the write is dropped.
- Read:
  - Combinational, zero latency, one per port.
  - raddr=0 with ZERO_REG=1 returns 0.
  - raddr >= DEPTH returns 0.
  - BYPASS=1 and we=1 and waddr==raddr[k] and the address is writable: rdata[k]=wdata in the same cycle.
  - BYPASS=0: rdata[k] shows the old value until the following cycle.
  - Multiple ports reading the same address return identical data.
- Scoreboard:
  - One pending bit per register.
  - In RUN, pend_set sets bit pend_addr. A write (we) to waddr clears bit waddr.
  - pend_set and a write to the same address in one cycle: set wins (new producer overrides completing one).
  - Register 0 (ZERO_REG=1) and out-of-range addresses are never pending.
  - pend[k] is combinational from the stored bits and raddr. It is not bypassed: a clearing write is visible in pend the cycle after.
- Reset values: init_busy=1 (from the first cycle after reset is sampled until the sweep completes), rdata=0, pend=0.
- No X may propagate to rdata for any in-range address after init_busy falls.

Test Plan:
- Reset clear: preload r5=0xDEAD via writes, pulse reset 1 cycle, DEPTH=32 -> init_busy high exactly 32 cycles; then raddr0=5 reads 0x00000000, pend=0.
- Reset mid-sweep: reassert reset at sweep cycle 10 -> ptr restarts; init_busy stays high a further 32 cycles after release; a we during CLEAR (r3=7) -> r3 reads 0 after RUN.
- Write/read + zero register: write r1=0x12345678, r2=0xFFFFFFFF, r0=0xAAAA -> next cycle raddr={r0,r1,r2} on NRD=3 reads 0, 0x12345678, 0xFFFFFFFF.
- Bypass: BYPASS=1, we=1 waddr=7 wdata=0x55 with raddr0=7 same cycle -> rdata0=0x55 same cycle. BYPASS=0 build -> old value, then 0x55 next cycle.
- Scoreboard: pend_set r9 -> pend[0]=1 next cycle for raddr0=9. Same-cycle pend_set r9 and write r9 -> still 1. Later write r9 alone -> pend[0]=0 the following cycle. pend_set r0 -> pend stays 0.
- Non-power-of-two DEPTH=24: write r30=0x1 -> dropped; raddr=30 reads 0; sweep length 24 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port architectural register file with write-to-read bypass,
// sequenced clear-on-reset sweep and a per-register pending scoreboard.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_busy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                pend_set,
  input  logic [AW-1:0]       pend_addr,
  output logic [NRD-1:0]      pend
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [AW-1:0]     ptr_r;
  logic [XLEN-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_r;
  logic              run_s;
  logic              wr_ok_s;
  logic              ps_ok_s;
  logic [AW-1:0]     ra_s;

  // An address is architecturally live: inside the array and not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: leave CLEAR once the last entry has been swept
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_L) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    init_busy = 1'b1;
    run_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        init_busy = 1'b0;
        run_s     = 1'b1;
      end
      ST_CLEAR: begin
        init_busy = 1'b1;
        run_s     = 1'b0;
      end
      default: begin
        init_busy = 1'b1;
        run_s     = 1'b0;
      end
    endcase
  end

  // Write and pending-set qualification
  always_comb begin
    wr_ok_s = run_s && we && addr_ok(waddr);
    ps_ok_s = run_s && pend_set && addr_ok(pend_addr);
  end

  // Sweep pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      ptr_r <= ptr_r + AW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Storage array: the sweep is its only initialisation, so no reset term here
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_CLEAR)) begin
      mem_r[ptr_r] <= '0;
    end else if (!reset && wr_ok_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Pending scoreboard; set is applied last so a new producer wins over a completing one
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= '0;
    end else begin
      if (wr_ok_s) begin
        pend_r[waddr] <= 1'b0;
      end
      if (ps_ok_s) begin
        pend_r[pend_addr] <= 1'b1;
      end
    end
  end

  // Read ports and pending lookup; pend is deliberately not bypassed
  always_comb begin
    rdata = '0;
    pend  = '0;
    ra_s  = '0;
    for (int k = 0; k < NRD; k++) begin
      ra_s = raddr[k*AW +: AW];
      if (!run_s || !addr_ok(ra_s)) begin
        rdata[k*XLEN +: XLEN] = '0;
        pend[k]               = 1'b0;
      end else if ((BYPASS != 0) && wr_ok_s && (waddr == ra_s)) begin
        rdata[k*XLEN +: XLEN] = wdata;
        pend[k]               = pend_r[ra_s];
      end else begin
        rdata[k*XLEN +: XLEN] = mem_r[ra_s];
        pend[k]               = pend_r[ra_s];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 3-port bypassing build,
// a non-bypassing build and a non-power-of-two (24-entry) build share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic [14:0] raddr_m;
  logic [95:0] rdata_m;
  logic [2:0]  pend_m;
  logic        busy_m;

  logic [4:0]  raddr_nb;
  logic [31:0] rdata_nb;
  logic [0:0]  pend_nb;
  logic        busy_nb;

  logic [4:0]  raddr_np;
  logic [31:0] rdata_np;
  logic [0:0]  pend_np;
  logic        busy_np;

  int checks = 0;
  int failures = 0;
  int c_m, c_nb, c_np;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(3), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .init_busy(busy_m), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_m), .rdata(rdata_m), .pend_set(pend_set), .pend_addr(pend_addr), .pend(pend_m));

  regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(1), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .init_busy(busy_nb), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_nb), .rdata(rdata_nb), .pend_set(pend_set), .pend_addr(pend_addr), .pend(pend_nb));

  regfile_mp #(.XLEN(32), .DEPTH(24), .NRD(1), .ZERO_REG(1), .BYPASS(1)) u_np (
    .clk(clk), .reset(reset), .init_busy(busy_np), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_np), .rdata(rdata_np), .pend_set(pend_set), .pend_addr(pend_addr), .pend(pend_np));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges after reset release until each build drops init_busy (0 = never).
  task automatic wait_sweep(output int cm, output int cnb, output int cnp);
    cm = 0; cnb = 0; cnp = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (!busy_m && cm == 0) cm = cyc;
      if (!busy_nb && cnb == 0) cnb = cyc;
      if (!busy_np && cnp == 0) cnp = cyc;
      if (cm != 0 && cnb != 0 && cnp != 0) break;
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    pend_set = 1'b0; pend_addr = 5'd0;
    raddr_m = 15'd0; raddr_nb = 5'd0; raddr_np = 5'd0;

    // Power-up reset and initial sweep
    tick(); tick();
    raddr_m = {5'd0, 5'd0, 5'd5};
    #1;
    chk("busy_in_reset", {63'd0, busy_m}, 64'd1);
    chk("rdata_in_clear", {32'd0, rdata_m[31:0]}, 64'd0);
    reset = 1'b0;
    wait_sweep(c_m, c_nb, c_np);
    chk("sweep_len_32", c_m, 64'd32);
    chk("sweep_len_32_nb", c_nb, 64'd32);
    chk("sweep_len_24", c_np, 64'd24);

    // Preload r5, then a single-cycle reset pulse must clear it
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000DEAD;
    tick();
    we = 1'b0;
    #1;
    chk("r5_preload", {32'd0, rdata_m[31:0]}, 64'h0000DEAD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("busy_after_pulse", {63'd0, busy_m}, 64'd1);
    wait_sweep(c_m, c_nb, c_np);
    chk("pulse_busy_len", c_m, 64'd32);
    chk("r5_cleared", {32'd0, rdata_m[31:0]}, 64'd0);
    chk("pend_after_reset", {61'd0, pend_m}, 64'd0);

    // Writes and pend_set during CLEAR are ignored (ptr already past r3)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'd7; pend_set = 1'b1; pend_addr = 5'd3;
    tick();
    we = 1'b0; pend_set = 1'b0;
    wait_sweep(c_m, c_nb, c_np);
    raddr_m = {5'd0, 5'd0, 5'd3};
    #1;
    chk("clear_write_dropped", {32'd0, rdata_m[31:0]}, 64'd0);
    chk("clear_pend_dropped", {61'd0, pend_m}, 64'd0);

    // Reset reasserted at sweep cycle 10 restarts the full sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_sweep(c_m, c_nb, c_np);
    chk("restart_len", c_m, 64'd32);

    // Write/read across three ports, zero register drops its write
    we = 1'b1; waddr = 5'd1; wdata = 32'h12345678;
    tick();
    waddr = 5'd2; wdata = 32'hFFFFFFFF;
    tick();
    waddr = 5'd0; wdata = 32'h0000AAAA;
    tick();
    we = 1'b0;
    raddr_m = {5'd2, 5'd1, 5'd0};
    #1;
    chk("rd_r0", {32'd0, rdata_m[31:0]}, 64'd0);
    chk("rd_r1", {32'd0, rdata_m[63:32]}, 64'h12345678);
    chk("rd_r2", {32'd0, rdata_m[95:64]}, 64'hFFFFFFFF);
    raddr_m = {5'd1, 5'd1, 5'd1};
    #1;
    chk("same_addr_p0", {32'd0, rdata_m[31:0]}, 64'h12345678);
    chk("same_addr_p2", {32'd0, rdata_m[95:64]}, 64'h12345678);

    // Bypass versus registered-only read
    raddr_m = {5'd0, 5'd0, 5'd7}; raddr_nb = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h00000055;
    #1;
    chk("bypass_same_cycle", {32'd0, rdata_m[31:0]}, 64'h55);
    chk("nobypass_old", {32'd0, rdata_nb}, 64'd0);
    tick();
    we = 1'b0;
    #1;
    chk("nobypass_next", {32'd0, rdata_nb}, 64'h55);
    raddr_m = {5'd0, 5'd0, 5'd0};
    we = 1'b1; waddr = 5'd0; wdata = 32'h00000077;
    #1;
    chk("bypass_r0_zero", {32'd0, rdata_m[31:0]}, 64'd0);
    tick();
    we = 1'b0;

    // Scoreboard: set, set-vs-clear priority, clear latency, r0 never pending
    raddr_m = {5'd0, 5'd9, 5'd9};
    pend_set = 1'b1; pend_addr = 5'd9;
    #1;
    chk("pend_not_yet", {61'd0, pend_m}, 64'd0);
    tick();
    pend_set = 1'b0;
    #1;
    chk("pend_set_r9", {61'd0, pend_m}, 64'd3);
    pend_set = 1'b1; pend_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'd1;
    tick();
    pend_set = 1'b0; we = 1'b0;
    #1;
    chk("pend_set_wins", {61'd0, pend_m}, 64'd3);
    we = 1'b1; waddr = 5'd9; wdata = 32'd2;
    #1;
    chk("pend_clear_latency", {61'd0, pend_m}, 64'd3);
    tick();
    we = 1'b0;
    #1;
    chk("pend_cleared", {61'd0, pend_m}, 64'd0);
    raddr_m = {5'd0, 5'd0, 5'd0};
    pend_set = 1'b1; pend_addr = 5'd0;
    tick();
    pend_set = 1'b0;
    #1;
    chk("pend_r0", {61'd0, pend_m}, 64'd0);

    // Non-power-of-two depth: out-of-range write dropped, last entry usable
    raddr_np = 5'd30; raddr_m = {5'd0, 5'd0, 5'd30};
    we = 1'b1; waddr = 5'd30; wdata = 32'd1;
    tick();
    we = 1'b0;
    #1;
    chk("np_oob_read", {32'd0, rdata_np}, 64'd0);
    chk("d32_r30", {32'd0, rdata_m[31:0]}, 64'd1);
    we = 1'b1; waddr = 5'd23; wdata = 32'h00000ABC;
    tick();
    we = 1'b0;
    raddr_np = 5'd23;
    #1;
    chk("np_r23", {32'd0, rdata_np}, 64'hABC);
    raddr_np = 5'd30;
    pend_set = 1'b1; pend_addr = 5'd30;
    tick();
    pend_set = 1'b0;
    #1;
    chk("np_oob_pend", {63'd0, pend_np}, 64'd0);
    chk("d32_pend_r30", {61'd0, pend_m}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
